// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter (MDU over ALU) feeding the register file write port, plus
// a pending-register scoreboard for MDU results. Optional bypass: WB_BYPASS_EN.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pending,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  byp_rs1,
  input  logic [4:0]  byp_rs2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2,
`endif
  output logic [4:0]  rd,
  output logic        rd_wd_en,
  output logic [31:0] rD
);

  logic        mdu_acc;
  logic        alu_acc;
  logic        wen_d, wen_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] wd_d, wd_q;
  logic [31:0] pending_d, pending_q;

  // Readies depend only on mdu_valid and reset, never on alu_valid.
  assign mdu_ready = rst_n;
  assign alu_ready = rst_n & ~mdu_valid;
  assign mdu_acc   = mdu_valid & mdu_ready;
  assign alu_acc   = alu_valid & alu_ready;

  always_comb begin
    wen_d = 1'b0;
    rd_d  = rd_q;
    wd_d  = wd_q;
    if (mdu_acc) begin
      rd_d  = mdu_rd;
      wd_d  = mdu_data;
      wen_d = (mdu_rd != 5'd0);
    end else if (alu_acc) begin
      rd_d  = alu_rd;
      wd_d  = alu_data;
      wen_d = (alu_rd != 5'd0);
    end
  end

  // Set is applied after clear so a fresh issue supersedes a completing result.
  always_comb begin
    pending_d = pending_q;
    if (mdu_acc) pending_d[mdu_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      rd_q      <= 5'd0;
      wd_q      <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      wen_q     <= wen_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
    end
  end

  assign rd_wd_en = wen_q;
  assign rd       = rd_q;
  assign rD       = wd_q;
  assign pending  = pending_q;

`ifdef WB_BYPASS_EN
  // Covers the cycle where the register file has not yet committed the write.
  assign byp_hit1  = wen_q & (rd_q == byp_rs1) & (byp_rs1 != 5'd0);
  assign byp_hit2  = wen_q & (rd_q == byp_rs2) & (byp_rs2 != 5'd0);
  assign byp_data1 = byp_hit1 ? wd_q : 32'd0;
  assign byp_data2 = byp_hit2 ? wd_q : 32'd0;
`endif

`ifndef SYNTHESIS
  // Decode must never re-issue to a register still awaiting its MDU result.
  always_ff @(posedge clk) begin
    if (rst_n && issue_valid && (issue_rd != 5'd0) && !(mdu_acc && (mdu_rd == issue_rd)))
      assert (!pending_q[issue_rd]);
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-register scoreboard for the RV32I+M core. It accepts results from the single-cycle ALU and the multi-cycle MDU (MUL/DIV) over valid/ready handshakes and drives the register file write port (`rd`, `rd_wd_en`, `rD`) with at most one write per cycle. It also tracks which destination registers have an outstanding MDU operation, so decode can stall on RAW hazards.

## Interface
- No parameters; the data width is fixed at 32 and the register index at 5.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `alu_valid` in 1: ALU result is valid.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU result is accepted this cycle.
- `mdu_valid` in 1: MDU result is valid.
- `mdu_rd` in 5: MDU destination register.
- `mdu_data` in 32: MDU result.
- `mdu_ready` out 1: MDU result is accepted this cycle.
- `issue_valid` in 1: an MDU operation is issued this cycle.
- `issue_rd` in 5: destination register of the issued MDU operation.
- `pending` out 32: bit i set means xi awaits an MDU write-back.
- `rd` out 5: register file write index.
- `rd_wd_en` out 1: register file write enable.
- `rD` out 32: register file write data.
- Present only with `WB_BYPASS_EN`:
  - `byp_rs1` in 5 and `byp_rs2` in 5: source indices being read.
  - `byp_hit1` out 1 and `byp_hit2` out 1: bypass hit flags.
  - `byp_data1` out 32 and `byp_data2` out 32: bypass data.

## Operation
- **Arbitration (combinational, fixed priority, MDU first):**
  - `mdu_ready` = `rst_n`.
  - `alu_ready` = `rst_n` & !`mdu_valid`.
  - Acceptance = valid & ready on the same rising edge.
- **Write stage (registered):**
  - On acceptance, the stage captures index and data from the winning source.
  - `rd_wd_en` is set next cycle only if the captured index != 0.
  - A write to x0 is handshaken and discarded: `rd_wd_en` stays 0.
  - With no acceptance, `rd_wd_en` = 0 next cycle. `rd` and `rD` hold their last values and are don't-care while disabled.
- **Scoreboard (32 flops, bit 0 tied to 0):**
  - Set: `issue_valid` with `issue_rd` != 0 sets `pending[issue_rd]`.
  - Clear: MDU acceptance clears `pending[mdu_rd]`. An ALU write never clears a bit.
  - Same register set and cleared on the same edge: set wins, because the new issue supersedes the old result.
  - Different registers: both updates take effect.
  - A clear of a bit that is not set is harmless.
  - Decode must not issue a second MDU op to an already-pending register. This is not checked in RTL and is flagged by an assertion in simulation only.
- **Reset:** when `rst_n` = 0 at an edge:
  - `rd_wd_en`=0, `rd`=0, `rD`=0, `pending`=0.
  - `byp_*` outputs = 0.
  - Both readies are 0 while `rst_n` is low, so no handshake completes.
  - A result presented during reset is dropped. Sources re-present it after reset.

## Timing
- Acceptance to write: 1 cycle. Accepted at edge N, `rd_wd_en`=1 during cycle N+1, and the register file commits at edge N+1.
- Throughput: 1 write per cycle, back-to-back, no bubbles.
- `pending` updates at the acceptance or issue edge and is visible in the following cycle.
- Readies are combinational from `mdu_valid` and `rst_n`. There is no combinational path from `alu_valid` to any ready.
- ALU starvation under continuous `mdu_valid` is allowed. The MDU produces at most 1 result per 2 cycles by construction.

## Configuration
- **`WB_BYPASS_EN` defined:**
  - `byp_hitN` = `rd_wd_en` & (`rd` == `byp_rsN`) & (`byp_rsN` != 0).
  - `byp_dataN` = hit ? `rD` : 0.
  - Both are combinational. This covers the write-before-read gap of the register file during cycle N+1.
- **Not defined:** the `byp_*` ports and logic are absent. Decode must stall one cycle on a match instead.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both valids high -> both readies 0, `rd_wd_en`=0, `pending`=0. First edge after release accepts the MDU result.
- Single ALU write: `alu_valid`=1, `alu_rd`=5, `alu_data`=32'hDEADBEEF -> next cycle `rd_wd_en`=1, `rd`=5, `rD`=32'hDEADBEEF.
- Conflict: both valid, `alu_rd`=3/32'h11, `mdu_rd`=4/32'h22 -> cycle 1 writes x4=32'h22 with `alu_ready`=0. ALU is held and x3=32'h11 is written the cycle after.
- x0 discard: `alu_valid`=1, `alu_rd`=0, data 32'hFFFFFFFF -> `alu_ready`=1, `rd_wd_en` stays 0. `issue_rd`=0 leaves `pending`=0.
- Scoreboard: issue to x7 -> `pending`=32'h80. MDU result to x7 at the same edge as a new issue to x7 -> bit stays 1. A later MDU result to x7 -> `pending`=0.
- Bypass (`WB_BYPASS_EN`): ALU writes x9=32'h1234, `byp_rs1`=9 and `byp_rs2`=0 during the write cycle -> `byp_hit1`=1, `byp_data1`=32'h1234, `byp_hit2`=0.
